// File: rtl/stream_config_queue.sv
// Per-stream configuration distributor: decodes config writes into per-stream
// (select, type) descriptor queues, each drained through split ready/valid halves.
module stream_config_queue #(
    parameter int unsigned NUM_STREAMS = 4,
    parameter int unsigned FIFO_DEPTH  = 64,
    parameter int unsigned SELECT_BITS = 8,
    parameter int unsigned TYPE_BITS   = 4,
    parameter int unsigned DATA_BITS   = 32,
    parameter int unsigned ADDR_BITS   = 8,
    parameter logic [31:0] BLOCK_ID    = 32'h5343_5132
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     wr_valid,
    input  logic [ADDR_BITS-1:0]                     wr_addr,
    input  logic [DATA_BITS-1:0]                     wr_data,
    input  logic                                     rd_req,
    input  logic [ADDR_BITS-1:0]                     rd_addr,
    output logic                                     rd_valid,
    output logic [DATA_BITS-1:0]                     rd_data,
    output logic [NUM_STREAMS-1:0]                   sel_valid,
    input  logic [NUM_STREAMS-1:0]                   sel_ready,
    output logic [NUM_STREAMS-1:0][SELECT_BITS-1:0]  sel_data,
    output logic [NUM_STREAMS-1:0]                   type_valid,
    input  logic [NUM_STREAMS-1:0]                   type_ready,
    output logic [NUM_STREAMS-1:0][TYPE_BITS-1:0]    type_data
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = SELECT_BITS + TYPE_BITS;

    logic [DW-1:0]          r_mem      [NUM_STREAMS][FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr   [NUM_STREAMS];
    logic [AW-1:0]          r_rd_ptr   [NUM_STREAMS];
    logic [CW-1:0]          r_count    [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] r_sel_taken;
    logic [NUM_STREAMS-1:0] r_type_taken;
    logic [NUM_STREAMS-1:0] r_ovf;
    logic                   r_rd_valid;
    logic [DATA_BITS-1:0]   r_rd_data;

    logic [NUM_STREAMS-1:0] w_nonempty;
    logic [NUM_STREAMS-1:0] w_sel_hs;
    logic [NUM_STREAMS-1:0] w_type_hs;
    logic [NUM_STREAMS-1:0] w_push;
    logic [NUM_STREAMS-1:0] w_pop;
    logic [NUM_STREAMS-1:0] w_flush;
    logic [NUM_STREAMS-1:0] w_ovf_set;
    logic                   w_ctrl_wr;
    logic                   w_ovf_clr;
    logic [DW-1:0]          w_desc;
    logic [DATA_BITS-1:0]   w_rd_mux;
    logic                   w_unused;

    assign w_desc    = wr_data[DW-1:0];
    assign w_ctrl_wr = wr_valid && (wr_addr == ADDR_BITS'(NUM_STREAMS + 1));
    assign w_ovf_clr = w_ctrl_wr && wr_data[31];
    assign w_unused  = ^wr_data;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;

    always_comb begin
        w_nonempty = '0;
        w_sel_hs   = '0;
        w_type_hs  = '0;
        w_push     = '0;
        w_pop      = '0;
        w_flush    = '0;
        w_ovf_set  = '0;
        sel_valid  = '0;
        type_valid = '0;
        sel_data   = '0;
        type_data  = '0;
        for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
            logic w_push_req;
            logic w_full;
            w_push_req    = wr_valid && ((wr_addr == ADDR_BITS'(i)) ||
                                         (wr_addr == ADDR_BITS'(NUM_STREAMS)));
            w_full        = (r_count[i] == CW'(FIFO_DEPTH));
            w_nonempty[i] = (r_count[i] != '0);
            sel_valid[i]  = w_nonempty[i] && !r_sel_taken[i];
            type_valid[i] = w_nonempty[i] && !r_type_taken[i];
            sel_data[i]   = r_mem[i][r_rd_ptr[i]][SELECT_BITS-1:0];
            type_data[i]  = r_mem[i][r_rd_ptr[i]][DW-1:SELECT_BITS];
            w_sel_hs[i]   = sel_valid[i] && sel_ready[i];
            w_type_hs[i]  = type_valid[i] && type_ready[i];
            w_flush[i]    = w_ctrl_wr && wr_data[i];
            // Full is judged on the registered count, so a same-cycle pop never frees a slot
            w_push[i]     = w_push_req && !w_full && !w_flush[i];
            w_ovf_set[i]  = w_push_req && w_full && !w_flush[i];
            w_pop[i]      = w_nonempty[i] && !w_flush[i] &&
                            (r_sel_taken[i] || w_sel_hs[i]) &&
                            (r_type_taken[i] || w_type_hs[i]);
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (rd_addr == ADDR_BITS'(0)) w_rd_mux = DATA_BITS'(BLOCK_ID);
        if (rd_addr == ADDR_BITS'(1)) w_rd_mux = DATA_BITS'(NUM_STREAMS);
        if (rd_addr == ADDR_BITS'(2)) w_rd_mux = DATA_BITS'(FIFO_DEPTH);
        if (rd_addr == ADDR_BITS'(3)) w_rd_mux = DATA_BITS'(r_ovf);
        for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
            if (rd_addr == ADDR_BITS'(4 + i)) w_rd_mux = DATA_BITS'(r_count[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_sel_taken  <= '0;
            r_type_taken <= '0;
            r_ovf        <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
                if (w_flush[i]) begin
                    r_wr_ptr[i] <= '0;
                    r_rd_ptr[i] <= '0;
                    r_count[i]  <= '0;
                end else begin
                    if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + AW'(1);
                    if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + AW'(1);
                    r_count[i] <= r_count[i] + CW'(w_push[i]) - CW'(w_pop[i]);
                end
                if (w_flush[i] || w_pop[i]) begin
                    r_sel_taken[i]  <= 1'b0;
                    r_type_taken[i] <= 1'b0;
                end else begin
                    r_sel_taken[i]  <= r_sel_taken[i] || w_sel_hs[i];
                    r_type_taken[i] <= r_type_taken[i] || w_type_hs[i];
                end
            end
            r_ovf      <= (w_ovf_clr ? '0 : r_ovf) | w_ovf_set;
            r_rd_valid <= rd_req;
            if (rd_req) r_rd_data <= w_rd_mux;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
            if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= w_desc;
        end
    end

endmodule
